// File: rtl/exp_sum_accumulator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exp_sum_accumulator_pkg                                          |
// | Purpose  : Shared types and helpers for the softmax exponent-sum front end.|
// |            Holds the FSM state encoding, the log-sum-exp correction        |
// |            constants and the unsigned saturation helper.                   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package exp_sum_accumulator_pkg;

  // Collect elements until the vector is full, then hold it for the consumer.
  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  // log2(2^a + 2^b) = max + log2(1 + 2^-|a-b|). In integer steps the
  // correction rounds to 1 for distances 0 and 1, and to 0 beyond that.
  localparam int unsigned CORR_D0  = 0;
  localparam int unsigned CORR_D1  = 1;
  localparam int unsigned CORR_VAL = 1;

  // Clamp an unsigned value to the largest number representable in `width`
  // bits. Callers keep width below 64.
  function automatic logic [63:0] sat_clamp(input logic [63:0] value,
                                            input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage : exp_sum_accumulator_pkg
`default_nettype wire

// File: rtl/exp_sum_accumulator_lse_combine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lse_combine                                                     |
// | Purpose  : Combines the running log2-domain sum with one new element:      |
// |            result = sat(max(acc, x) + corr(|acc - x|)).                    |
// |            Build option LSE_CORR_EN: when defined the correction term is   |
// |            applied; when undefined corr is 0 and the result is max().      |
// | Ports    : acc_i    in  EXP_WIDTH  running sum so far                      |
// |            x_i      in  EXP_WIDTH  new element, zero-extended              |
// |            result_o out EXP_WIDTH  saturated combined sum                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lse_combine
  import exp_sum_accumulator_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 9
) (
  input  logic [EXP_WIDTH-1:0] acc_i,
  input  logic [EXP_WIDTH-1:0] x_i,
  output logic [EXP_WIDTH-1:0] result_o
);

  logic                 w_acc_ge;
  logic [EXP_WIDTH-1:0] w_max;
  logic [EXP_WIDTH-1:0] w_diff;
  logic [EXP_WIDTH-1:0] w_corr;
  logic [EXP_WIDTH:0]   w_sum;

  assign w_acc_ge = (acc_i >= x_i);
  assign w_max    = w_acc_ge ? acc_i : x_i;
  assign w_diff   = w_acc_ge ? (acc_i - x_i) : (x_i - acc_i);

`ifdef LSE_CORR_EN
  assign w_corr = ((w_diff == EXP_WIDTH'(CORR_D0)) || (w_diff == EXP_WIDTH'(CORR_D1)))
                  ? EXP_WIDTH'(CORR_VAL) : '0;
`else
  // Correction disabled: the reduction degenerates to a plain maximum.
  assign w_corr = '0;
`endif

  // One extra bit catches the carry out of max+corr before clamping.
  assign w_sum    = {1'b0, w_max} + {1'b0, w_corr};
  assign result_o = EXP_WIDTH'(sat_clamp(64'(w_sum), EXP_WIDTH));

endmodule : lse_combine
`default_nettype wire

// File: rtl/exp_sum_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exp_sum_accumulator                                             |
// | Purpose  : Serial front end of the softmax exponent path. Collects         |
// |            NUM_INPUTS elements over a valid/ready stream into a packed     |
// |            vector while folding them into a running log2-domain sum, then  |
// |            holds vector and sum until the downstream consumes them.        |
// |            Build option LSE_CORR_EN selects max-plus-correction (defined)  |
// |            or plain max (undefined); it is tested inside lse_combine only. |
// | Ports    : clk       in  1            clock, rising edge                   |
// |            rst       in  1            synchronous active-high reset        |
// |            in_valid  in  1            upstream element valid               |
// |            in_ready  out 1            element accepted this cycle          |
// |            in_data   in  MANT_WIDTH   unsigned element                     |
// |            out_valid out 1            vector and exp_sum valid             |
// |            out_ready in  1            downstream consumes vector           |
// |            input_bus out N*MANT_WIDTH element k at [k*MANT_WIDTH +: ...]   |
// |            exp_sum   out EXP_WIDTH    log2-domain sum of the vector        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module exp_sum_accumulator
  import exp_sum_accumulator_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 10,
  parameter int unsigned EXP_WIDTH  = 9,
  parameter int unsigned MANT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MANT_WIDTH-1:0]            in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*MANT_WIDTH-1:0] input_bus,
  output logic [EXP_WIDTH-1:0]             exp_sum
);

  localparam int unsigned CNT_W = $clog2(NUM_INPUTS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [EXP_WIDTH-1:0] acc_q, acc_d;
  logic [MANT_WIDTH-1:0] slot_q [NUM_INPUTS];

  logic                 w_accept;
  logic [EXP_WIDTH-1:0] w_x;
  logic [EXP_WIDTH-1:0] w_combined;

  assign w_x = EXP_WIDTH'(in_data);

  lse_combine #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_lse_combine (
    .acc_i    (acc_q),
    .x_i      (w_x),
    .result_o (w_combined)
  );

  // Next state and handshake outputs. in_ready/out_valid depend only on the
  // state register (and rst), never on in_valid or out_ready.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        in_ready = ~rst;
        w_accept = in_valid & ~rst;
        if (w_accept) begin
          // The first element seeds the sum; later ones fold into it.
          acc_d = (count_q == '0) ? w_x : w_combined;
          if (count_q == CNT_W'(NUM_INPUTS - 1)) begin
            count_d = '0;
            state_d = ST_HOLD;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  // Element buffer: only the slot addressed by count is written per beat, so
  // the held vector stays bit-stable while in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (w_accept && (count_q == CNT_W'(k))) begin
          slot_q[k] <= in_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pack
    assign input_bus[g*MANT_WIDTH +: MANT_WIDTH] = slot_q[g];
  end

  assign exp_sum = acc_q;

endmodule : exp_sum_accumulator
`default_nettype wire
